// File: rtl/mastermind_pkg.sv
// Shared definitions for the Mastermind score engine.
// Default sizes, FSM state encoding and a peg-extract helper.
package mastermind_pkg;

   localparam int NUM_PEGS_DEF    = 4;
   localparam int COLOR_BITS_DEF  = 3;
   localparam int MAX_GUESSES_DEF = 8;

   // Widest code bus and widest peg the helper supports.
   localparam int PEG_BUS_MAX = 256;
   localparam int PEG_MAX_CB  = 8;

   typedef enum logic [1:0] {
      IDLE   = 2'd0,
      COUNT  = 2'd1,
      SUM    = 2'd2,
      FINISH = 2'd3
   } state_t;

   // Peg i of a packed bus, pegs cb bits wide, zero-extended.
   function automatic logic [PEG_MAX_CB-1:0] peg_at(
      input logic [PEG_BUS_MAX-1:0] bus,
      input int                     i,
      input int                     cb
   );
      logic [PEG_BUS_MAX-1:0] sh;
      logic [PEG_MAX_CB-1:0]  mask;
      sh   = bus >> (i * cb);
      mask = ~({PEG_MAX_CB{1'b1}} << cb);
      return sh[PEG_MAX_CB-1:0] & mask;
   endfunction

endpackage

// File: rtl/mm_color_histogram.sv
// Pair of per-colour histograms (code side and guess side).
// Ports: clk, resetn (sync, active-low), clr (zero all counters),
//   inc_a/idx_a and inc_b/idx_b bump the code/guess counter of a colour,
//   rd_idx selects a colour, rd_min = min(code count, guess count).
module mm_color_histogram
   import mastermind_pkg::*;
#(
   parameter int  CB = COLOR_BITS_DEF,
   parameter int  SW = 3,
   localparam int NUM_COLORS = 2**CB
) (
   input  logic          clk,
   input  logic          resetn,
   input  logic          clr,
   input  logic          inc_a,
   input  logic [CB-1:0] idx_a,
   input  logic          inc_b,
   input  logic [CB-1:0] idx_b,
   input  logic [CB-1:0] rd_idx,
   output logic [SW-1:0] rd_min
);

   logic [SW-1:0] hc_q [NUM_COLORS];
   logic [SW-1:0] hc_d [NUM_COLORS];
   logic [SW-1:0] hg_q [NUM_COLORS];
   logic [SW-1:0] hg_d [NUM_COLORS];

   logic [SW-1:0] rd_c;
   logic [SW-1:0] rd_g;

   always_comb begin
      hc_d = hc_q;
      hg_d = hg_q;
      if (clr) begin
         for (int c = 0; c < NUM_COLORS; c++) begin
            hc_d[c] = '0;
            hg_d[c] = '0;
         end
      end else begin
         if (inc_a) begin
            hc_d[idx_a] = hc_q[idx_a] + SW'(1);
         end
         if (inc_b) begin
            hg_d[idx_b] = hg_q[idx_b] + SW'(1);
         end
      end
   end

   always_comb begin
      rd_c   = hc_q[rd_idx];
      rd_g   = hg_q[rd_idx];
      rd_min = (rd_c < rd_g) ? rd_c : rd_g;
   end

   always_ff @(posedge clk) begin
      if (!resetn) begin
         for (int c = 0; c < NUM_COLORS; c++) begin
            hc_q[c] <= '0;
            hg_q[c] <= '0;
         end
      end else begin
         hc_q <= hc_d;
         hg_q <= hg_d;
      end
   end

endmodule

// File: rtl/mastermind_score_engine.sv
// Sequential Mastermind scorer: red/white pegs via colour histograms,
// guess counting and sticky win/lose flags.
// Ports: clk, resetn (sync, active-low), new_game (clear game),
//   start (score code/guess), code/guess (packed pegs, peg i at [i*CB +: CB]),
//   busy, done (1-cycle pulse), red, white, guess_count, win, lose.
module mastermind_score_engine
   import mastermind_pkg::*;
#(
   parameter int  NUM_PEGS    = NUM_PEGS_DEF,
   parameter int  COLOR_BITS  = COLOR_BITS_DEF,
   parameter int  MAX_GUESSES = MAX_GUESSES_DEF,
   localparam int NUM_COLORS  = 2**COLOR_BITS,
   localparam int CW          = NUM_PEGS * COLOR_BITS,
   localparam int SW          = $clog2(NUM_PEGS + 1),
   localparam int GW          = $clog2(MAX_GUESSES + 1)
) (
   input  logic          clk,
   input  logic          resetn,
   input  logic          new_game,
   input  logic          start,
   input  logic [CW-1:0] code,
   input  logic [CW-1:0] guess,
   output logic          busy,
   output logic          done,
   output logic [SW-1:0] red,
   output logic [SW-1:0] white,
   output logic [GW-1:0] guess_count,
   output logic          win,
   output logic          lose
);

   localparam int CB    = COLOR_BITS;
   localparam int IDX_N = (NUM_PEGS > NUM_COLORS) ? NUM_PEGS : NUM_COLORS;
   localparam int IW    = $clog2(IDX_N);

   state_t        state_q, state_d;
   logic [CW-1:0] code_q, code_d;
   logic [CW-1:0] guess_q, guess_d;
   logic [IW-1:0] idx_q, idx_d;
   logic [SW-1:0] red_acc_q, red_acc_d;
   logic [SW-1:0] total_acc_q, total_acc_d;
   logic [SW-1:0] red_q, red_d;
   logic [SW-1:0] white_q, white_d;
   logic [GW-1:0] gc_q, gc_d;
   logic          win_q, win_d;
   logic          lose_q, lose_d;

   logic          hist_clr;
   logic          hist_inc;
   logic [CB-1:0] code_peg;
   logic [CB-1:0] guess_peg;
   logic [CB-1:0] rd_idx;
   logic [SW-1:0] rd_min;
   logic [SW-1:0] total_sum;
   logic          win_next;
   logic [GW:0]   gc_plus;

   mm_color_histogram #(
      .CB (CB),
      .SW (SW)
   ) u_hist (
      .clk    (clk),
      .resetn (resetn),
      .clr    (hist_clr),
      .inc_a  (hist_inc),
      .idx_a  (code_peg),
      .inc_b  (hist_inc),
      .idx_b  (guess_peg),
      .rd_idx (rd_idx),
      .rd_min (rd_min)
   );

   always_comb begin
      code_peg  = CB'(peg_at(PEG_BUS_MAX'(code_q), int'(idx_q), CB));
      guess_peg = CB'(peg_at(PEG_BUS_MAX'(guess_q), int'(idx_q), CB));
      rd_idx    = CB'(idx_q);
      // Last colour's contribution must reach the white count on the
      // same edge, so use the post-add total here.
      total_sum = total_acc_q + rd_min;
      win_next  = (red_acc_q == SW'(NUM_PEGS));
      gc_plus   = {1'b0, gc_q} + (GW+1)'(1);
   end

   always_comb begin
      state_d     = state_q;
      code_d      = code_q;
      guess_d     = guess_q;
      idx_d       = idx_q;
      red_acc_d   = red_acc_q;
      total_acc_d = total_acc_q;
      red_d       = red_q;
      white_d     = white_q;
      gc_d        = gc_q;
      win_d       = win_q;
      lose_d      = lose_q;
      hist_clr    = 1'b0;
      hist_inc    = 1'b0;

      unique case (state_q)
         IDLE: begin
            if (start && !win_q && !lose_q) begin
               code_d      = code;
               guess_d     = guess;
               hist_clr    = 1'b1;
               red_acc_d   = '0;
               total_acc_d = '0;
               idx_d       = '0;
               state_d     = COUNT;
            end
         end
         COUNT: begin
            hist_inc = 1'b1;
            if (code_peg == guess_peg) begin
               red_acc_d = red_acc_q + SW'(1);
            end
            if (idx_q == IW'(NUM_PEGS - 1)) begin
               idx_d   = '0;
               state_d = SUM;
            end else begin
               idx_d = idx_q + IW'(1);
            end
         end
         SUM: begin
            total_acc_d = total_sum;
            if (idx_q == IW'(NUM_COLORS - 1)) begin
               idx_d   = '0;
               state_d = FINISH;
               red_d   = red_acc_q;
               // Every red match is also a colour match, so no underflow.
               white_d = total_sum - red_acc_q;
               if (gc_q != GW'(MAX_GUESSES)) begin
                  gc_d = gc_plus[GW-1:0];
               end
               win_d  = win_next;
               lose_d = !win_next &&
                        (gc_plus == (GW+1)'(MAX_GUESSES));
            end else begin
               idx_d = idx_q + IW'(1);
            end
         end
         FINISH: begin
            state_d = IDLE;
         end
         default: begin
            state_d = IDLE;
         end
      endcase

      // Abort wins over everything, including a same-cycle start.
      if (new_game) begin
         state_d  = IDLE;
         idx_d    = '0;
         red_d    = '0;
         white_d  = '0;
         gc_d     = '0;
         win_d    = 1'b0;
         lose_d   = 1'b0;
         hist_clr = 1'b1;
         hist_inc = 1'b0;
      end
   end

   always_ff @(posedge clk) begin
      if (!resetn) begin
         state_q     <= IDLE;
         code_q      <= '0;
         guess_q     <= '0;
         idx_q       <= '0;
         red_acc_q   <= '0;
         total_acc_q <= '0;
         red_q       <= '0;
         white_q     <= '0;
         gc_q        <= '0;
         win_q       <= 1'b0;
         lose_q      <= 1'b0;
      end else begin
         state_q     <= state_d;
         code_q      <= code_d;
         guess_q     <= guess_d;
         idx_q       <= idx_d;
         red_acc_q   <= red_acc_d;
         total_acc_q <= total_acc_d;
         red_q       <= red_d;
         white_q     <= white_d;
         gc_q        <= gc_d;
         win_q       <= win_d;
         lose_q      <= lose_d;
      end
   end

   assign busy        = (state_q != IDLE);
   assign done        = (state_q == FINISH);
   assign red         = red_q;
   assign white       = white_q;
   assign guess_count = gc_q;
   assign win         = win_q;
   assign lose        = lose_q;

endmodule
